// File: rtl/atm_account_server.sv
// rtl/atm_account_server.sv - bank-side account table and single-request transaction engine
module atm_account_server #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [W-1:0]     req_acct,
    input  logic [W-1:0]     req_pin,
    input  logic [W-1:0]     req_dst,
    input  logic [W-1:0]     req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [W-1:0]     rsp_balance,
    output logic [W-1:0]     rsp_dst_balance
);
    typedef enum logic [2:0] {IDLE, SRC_SCAN, DST_SCAN, EXEC, RESP} state_t;

    localparam logic [2:0] CMD_LOAD = 3'd0, CMD_AUTH = 3'd1, CMD_BAL = 3'd2,
                           CMD_DEP  = 3'd3, CMD_WDR  = 3'd4, CMD_XFER = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_NOACCT = 3'd1, ST_BADPIN = 3'd2, ST_FUNDS = 3'd3,
                           ST_OVERFLOW = 3'd4, ST_NODST = 3'd5, ST_BADCMD = 3'd6, ST_SAMEACCT = 3'd7;

    state_t state, state_n;

    logic [DEPTH-1:0] acct_valid;
    logic [W-1:0]     acct_num [DEPTH];
    logic [W-1:0]     acct_pin [DEPTH];
    logic [W-1:0]     acct_bal [DEPTH];

    logic [2:0]       cmd_q;
    logic [IDX_W-1:0] idx_q, scan_i, src_i, dst_i;
    logic [W-1:0]     acct_q, pin_q, dst_q, amt_q;
    logic             fail_q, exec_hold;
    logic [2:0]       fail_code;

    logic             src_hit, dst_hit, scan_last, cmd_direct, pin_ok, funds_ok;
    logic [W-1:0]     src_bal, dst_bal;
    logic [W:0]       dep_sum, xfer_sum;

    assign src_hit    = acct_valid[scan_i] && (acct_num[scan_i] == acct_q);
    assign dst_hit    = acct_valid[scan_i] && (acct_num[scan_i] == dst_q);
    assign scan_last  = (scan_i == IDX_W'(DEPTH - 1));
    assign cmd_direct = (cmd_q == CMD_LOAD) || (cmd_q > CMD_XFER);
    assign src_bal    = acct_bal[src_i];
    assign dst_bal    = acct_bal[dst_i];
    assign pin_ok     = (acct_pin[src_i] == pin_q);
    assign funds_ok   = (amt_q <= src_bal);
    assign dep_sum    = {1'b0, src_bal} + {1'b0, amt_q};
    assign xfer_sum   = {1'b0, dst_bal} + {1'b0, amt_q};

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_n = ((req_cmd == CMD_LOAD) || (req_cmd > CMD_XFER)) ? EXEC : SRC_SCAN;
            end
            SRC_SCAN: begin
                if (src_hit)
                    state_n = (cmd_q == CMD_XFER) ? DST_SCAN : EXEC;
                else if (scan_last)
                    state_n = EXEC;
            end
            DST_SCAN: begin
                if (dst_hit || scan_last)
                    state_n = EXEC;
            end
            EXEC: begin
                if (!exec_hold)
                    state_n = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Scan failures are only recorded here; EXEC publishes them so every response leaves from EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acct_valid      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                acct_num[i] <= '0;
                acct_pin[i] <= '0;
                acct_bal[i] <= '0;
            end
            cmd_q           <= '0;
            idx_q           <= '0;
            acct_q          <= '0;
            pin_q           <= '0;
            dst_q           <= '0;
            amt_q           <= '0;
            scan_i          <= '0;
            src_i           <= '0;
            dst_i           <= '0;
            fail_q          <= 1'b0;
            fail_code       <= '0;
            exec_hold       <= 1'b0;
            rsp_status      <= '0;
            rsp_balance     <= '0;
            rsp_dst_balance <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_q     <= req_cmd;
                        idx_q     <= req_idx;
                        acct_q    <= req_acct;
                        pin_q     <= req_pin;
                        dst_q     <= req_dst;
                        amt_q     <= req_amount;
                        scan_i    <= '0;
                        fail_q    <= 1'b0;
                        // Direct commands idle one EXEC cycle to line up with the lookup path.
                        exec_hold <= (req_cmd == CMD_LOAD) || (req_cmd > CMD_XFER);
                    end
                end
                SRC_SCAN: begin
                    if (src_hit) begin
                        src_i  <= scan_i;
                        scan_i <= '0;
                    end else if (scan_last) begin
                        fail_q    <= 1'b1;
                        fail_code <= ST_NOACCT;
                    end else begin
                        scan_i <= scan_i + 1'b1;
                    end
                end
                DST_SCAN: begin
                    if (dst_hit) begin
                        dst_i <= scan_i;
                        if (scan_i == src_i) begin
                            fail_q    <= 1'b1;
                            fail_code <= ST_SAMEACCT;
                        end
                    end else if (scan_last) begin
                        fail_q    <= 1'b1;
                        fail_code <= ST_NODST;
                    end else begin
                        scan_i <= scan_i + 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_hold) begin
                        exec_hold <= 1'b0;
                    end else begin
                        rsp_balance     <= '0;
                        rsp_dst_balance <= '0;
                        if (fail_q) begin
                            rsp_status <= fail_code;
                        end else if (cmd_q == CMD_LOAD) begin
                            acct_valid[idx_q] <= 1'b1;
                            acct_num[idx_q]   <= acct_q;
                            acct_pin[idx_q]   <= pin_q;
                            acct_bal[idx_q]   <= amt_q;
                            rsp_status        <= ST_OK;
                            rsp_balance       <= amt_q;
                        end else if (cmd_direct) begin
                            rsp_status <= ST_BADCMD;
                        end else if (!pin_ok) begin
                            rsp_status <= ST_BADPIN;
                        end else begin
                            rsp_status  <= ST_OK;
                            rsp_balance <= src_bal;
                            case (cmd_q)
                                CMD_DEP: begin
                                    if (dep_sum[W]) begin
                                        rsp_status <= ST_OVERFLOW;
                                    end else begin
                                        acct_bal[src_i] <= dep_sum[W-1:0];
                                        rsp_balance     <= dep_sum[W-1:0];
                                    end
                                end
                                CMD_WDR: begin
                                    if (!funds_ok) begin
                                        rsp_status <= ST_FUNDS;
                                    end else begin
                                        acct_bal[src_i] <= src_bal - amt_q;
                                        rsp_balance     <= src_bal - amt_q;
                                    end
                                end
                                CMD_XFER: begin
                                    rsp_dst_balance <= dst_bal;
                                    if (!funds_ok) begin
                                        rsp_status <= ST_FUNDS;
                                    end else if (xfer_sum[W]) begin
                                        rsp_status <= ST_OVERFLOW;
                                    end else begin
                                        acct_bal[src_i] <= src_bal - amt_q;
                                        acct_bal[dst_i] <= xfer_sum[W-1:0];
                                        rsp_balance     <= src_bal - amt_q;
                                        rsp_dst_balance <= xfer_sum[W-1:0];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
